// File: rtl/orbital_pkg.sv
// Shared symbol alphabet and state encoding for the orbital 2-bit link.
// Imported by both the transmit and receive ends.
package orbital_pkg;

  localparam logic [1:0] SYM_IDLE  = 2'b00;
  localparam logic [1:0] SYM_START = 2'b11;
  localparam logic [1:0] SYM_ZERO  = 2'b01;
  localparam logic [1:0] SYM_ONE   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_GAP
  } tx_state_t;

  function automatic logic [1:0] sym_of_bit(input logic b);
    return b ? SYM_ONE : SYM_ZERO;
  endfunction

endpackage

// File: rtl/orbital_symbol_tx_if.sv
// Word-in / symbol-out bundle of the orbital transmitter.
// master = word source, slave = transmitter.
interface orbital_symbol_tx_if #(
  parameter int DATA_W = 8
);

  logic              io_in_valid;
  logic              io_in_ready;
  logic [DATA_W-1:0] io_in_bits;
  logic [1:0]        io_out;
  logic              io_busy;
  logic              io_done;

  modport master (
    output io_in_valid,
    output io_in_bits,
    input  io_in_ready,
    input  io_out,
    input  io_busy,
    input  io_done
  );

  modport slave (
    input  io_in_valid,
    input  io_in_bits,
    output io_in_ready,
    output io_out,
    output io_busy,
    output io_done
  );

endinterface

// File: rtl/orbital_symbol_tx.sv
// Serialises words into START / data / parity frames of 2-bit symbols.
// Frames are separated by 1+MIN_IDLE idle symbols.
module orbital_symbol_tx
  import orbital_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MIN_IDLE = 0
) (
  input  logic               clock,
  input  logic               reset,
  orbital_symbol_tx_if.slave io
);

  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GW = (MIN_IDLE > 0) ? $clog2(MIN_IDLE + 1) : 1;

  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_W - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((MIN_IDLE > 0) ? (MIN_IDLE - 1) : 0);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] sh_next;
  logic              par_q, par_d;
  logic [CW-1:0]     bcnt_q, bcnt_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic [1:0]        sym_q, sym_d;
  logic              done_q, done_d;
  logic              ready;
  logic              hs;

  assign ready   = (state_q == S_IDLE) & ~reset;
  assign hs      = io.io_in_valid & ready;
  assign sh_next = shreg_q >> 1;

  // sym_d is the symbol of the state being entered, so io_out
  // lines up with state_q while staying a plain flop output.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    bcnt_d  = bcnt_q;
    gcnt_d  = gcnt_q;
    sym_d   = SYM_IDLE;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (hs) begin
          shreg_d = io.io_in_bits;
          par_d   = ^io.io_in_bits;
          bcnt_d  = '0;
          state_d = S_START;
          sym_d   = SYM_START;
        end
      end
      S_START: begin
        state_d = S_DATA;
        sym_d   = sym_of_bit(shreg_q[0]);
      end
      S_DATA: begin
        shreg_d = sh_next;
        if (bcnt_q == BIT_LAST) begin
          state_d = S_PARITY;
          sym_d   = sym_of_bit(par_q);
          done_d  = 1'b1;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
          sym_d  = sym_of_bit(sh_next[0]);
        end
      end
      S_PARITY: begin
        gcnt_d  = '0;
        state_d = (MIN_IDLE > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (gcnt_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      par_q   <= 1'b0;
      bcnt_q  <= '0;
      gcnt_q  <= '0;
      sym_q   <= SYM_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      bcnt_q  <= bcnt_d;
      gcnt_q  <= gcnt_d;
      sym_q   <= sym_d;
      done_q  <= done_d;
    end
  end

  assign io.io_in_ready = ready;
  assign io.io_out      = sym_q;
  assign io.io_busy     = (state_q != S_IDLE);
  assign io.io_done     = done_q;

endmodule

// File: tb/tb_orbital_symbol_tx.sv
// Directed and scoreboard bench for orbital_symbol_tx.
// dut_a: MIN_IDLE=0, dut_b: MIN_IDLE=3, both DATA_W=8.
module tb_orbital_symbol_tx;
  import orbital_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  orbital_symbol_tx_if #(.DATA_W(8)) bus_a ();
  orbital_symbol_tx_if #(.DATA_W(8)) bus_b ();

  orbital_symbol_tx #(.DATA_W(8), .MIN_IDLE(0)) dut_a (
    .clock (clock),
    .reset (reset),
    .io    (bus_a)
  );

  orbital_symbol_tx #(.DATA_W(8), .MIN_IDLE(3)) dut_b (
    .clock (clock),
    .reset (reset),
    .io    (bus_b)
  );

  typedef struct {
    logic [7:0]  word;
    logic [15:0] syms;
    logic [1:0]  par;
  } vec_t;

  vec_t vt [6];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready_a;
    int k;
    k = 0;
    while (bus_a.io_in_ready !== 1'b1 && k < 40) begin
      @(negedge clock);
      k++;
    end
    chk("ready_wait_a", 32'(bus_a.io_in_ready), 32'd1);
  endtask

  task automatic frame_a(input int idx);
    bus_a.io_in_valid = 1'b1;
    bus_a.io_in_bits  = vt[idx].word;
    @(negedge clock);
    bus_a.io_in_valid = 1'b0;
    bus_a.io_in_bits  = ~vt[idx].word;
    chk($sformatf("v%0d start", idx), 32'(bus_a.io_out), 32'(SYM_START));
    chk($sformatf("v%0d busy", idx), 32'(bus_a.io_busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk($sformatf("v%0d bit%0d", idx, i),
          32'(bus_a.io_out), 32'(vt[idx].syms[2*i +: 2]));
      chk($sformatf("v%0d done%0d", idx, i), 32'(bus_a.io_done), 32'd0);
    end
    @(negedge clock);
    chk($sformatf("v%0d parity", idx), 32'(bus_a.io_out), 32'(vt[idx].par));
    chk($sformatf("v%0d done", idx), 32'(bus_a.io_done), 32'd1);
    @(negedge clock);
    chk($sformatf("v%0d idle", idx), 32'(bus_a.io_out), 32'd0);
    chk($sformatf("v%0d nbusy", idx), 32'(bus_a.io_busy), 32'd0);
    chk($sformatf("v%0d ready", idx), 32'(bus_a.io_in_ready), 32'd1);
    chk($sformatf("v%0d ndone", idx), 32'(bus_a.io_done), 32'd0);
  endtask

  task automatic check_data_a(input string tag, input int idx);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk($sformatf("%s bit%0d", tag, i),
          32'(bus_a.io_out), 32'(vt[idx].syms[2*i +: 2]));
    end
    @(negedge clock);
    chk({tag, " parity"}, 32'(bus_a.io_out), 32'(vt[idx].par));
    chk({tag, " done"}, 32'(bus_a.io_done), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] w;
    logic [7:0] dec;
    logic       ok;
    logic [1:0] s;

    vt[0] = '{8'hA5, 16'h9966, 2'b01};
    vt[1] = '{8'h00, 16'h5555, 2'b01};
    vt[2] = '{8'hFF, 16'hAAAA, 2'b01};
    vt[3] = '{8'h01, 16'h5556, 2'b10};
    vt[4] = '{8'h80, 16'h9555, 2'b10};
    vt[5] = '{8'h3C, 16'h5AA5, 2'b01};

    bus_a.io_in_valid = 1'b0;
    bus_a.io_in_bits  = '0;
    bus_b.io_in_valid = 1'b0;
    bus_b.io_in_bits  = '0;

    // reset held for 3 cycles, valid offered to prove it is refused
    bus_a.io_in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("rst out", 32'(bus_a.io_out), 32'd0);
      chk("rst busy", 32'(bus_a.io_busy), 32'd0);
      chk("rst done", 32'(bus_a.io_done), 32'd0);
      chk("rst ready", 32'(bus_a.io_in_ready), 32'd0);
      chk("rst ready b", 32'(bus_b.io_in_ready), 32'd0);
    end
    bus_a.io_in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    chk("ready after rst", 32'(bus_a.io_in_ready), 32'd1);
    chk("out after rst", 32'(bus_a.io_out), 32'd0);

    for (int i = 0; i < 6; i++) frame_a(i);

    // back-to-back 0x00 then 0xFF, valid held high
    bus_a.io_in_valid = 1'b1;
    bus_a.io_in_bits  = 8'h00;
    @(negedge clock);
    chk("b2b start1", 32'(bus_a.io_out), 32'(SYM_START));
    bus_a.io_in_bits = 8'hFF;
    check_data_a("b2b f1", 1);
    @(negedge clock);
    chk("b2b gap", 32'(bus_a.io_out), 32'd0);
    chk("b2b gap ready", 32'(bus_a.io_in_ready), 32'd1);
    @(negedge clock);
    chk("b2b start2", 32'(bus_a.io_out), 32'(SYM_START));
    bus_a.io_in_valid = 1'b0;
    check_data_a("b2b f2", 2);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("b2b tail out", 32'(bus_a.io_out), 32'd0);
      chk("b2b tail busy", 32'(bus_a.io_busy), 32'd0);
    end

    // inputs wiggled mid-frame must not disturb the captured word
    bus_a.io_in_valid = 1'b1;
    bus_a.io_in_bits  = 8'h3C;
    @(negedge clock);
    chk("tog start", 32'(bus_a.io_out), 32'(SYM_START));
    for (int i = 0; i < 8; i++) begin
      bus_a.io_in_valid = i[0];
      bus_a.io_in_bits  = 8'($urandom);
      @(negedge clock);
      chk($sformatf("tog bit%0d", i),
          32'(bus_a.io_out), 32'(vt[5].syms[2*i +: 2]));
    end
    bus_a.io_in_valid = 1'b1;
    @(negedge clock);
    bus_a.io_in_valid = 1'b0;
    chk("tog parity", 32'(bus_a.io_out), 32'(vt[5].par));
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk("tog no extra", 32'(bus_a.io_out), 32'd0);
      chk("tog no busy", 32'(bus_a.io_busy), 32'd0);
    end

    // asynchronous reset in the middle of the data bits
    bus_a.io_in_valid = 1'b1;
    bus_a.io_in_bits  = 8'hFF;
    @(negedge clock);
    bus_a.io_in_valid = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("mid rst out", 32'(bus_a.io_out), 32'd0);
    chk("mid rst busy", 32'(bus_a.io_busy), 32'd0);
    chk("mid rst ready", 32'(bus_a.io_in_ready), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("mid rel ready", 32'(bus_a.io_in_ready), 32'd1);
    chk("mid rel out", 32'(bus_a.io_out), 32'd0);
    @(negedge clock);
    chk("mid no resume", 32'(bus_a.io_out), 32'd0);
    chk("mid no busy", 32'(bus_a.io_busy), 32'd0);

    // asynchronous reset while parity/done is showing
    bus_a.io_in_valid = 1'b1;
    bus_a.io_in_bits  = 8'h01;
    @(negedge clock);
    bus_a.io_in_valid = 1'b0;
    repeat (9) @(negedge clock);
    chk("pre rst done", 32'(bus_a.io_done), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("par rst done", 32'(bus_a.io_done), 32'd0);
    chk("par rst out", 32'(bus_a.io_out), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // MIN_IDLE=3: four idle symbols between frames
    bus_b.io_in_valid = 1'b1;
    bus_b.io_in_bits  = 8'h3C;
    @(negedge clock);
    chk("mi start1", 32'(bus_b.io_out), 32'(SYM_START));
    bus_b.io_in_bits = 8'h01;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk($sformatf("mi f1 bit%0d", i),
          32'(bus_b.io_out), 32'(vt[5].syms[2*i +: 2]));
    end
    @(negedge clock);
    chk("mi f1 parity", 32'(bus_b.io_out), 32'(vt[5].par));
    chk("mi f1 done", 32'(bus_b.io_done), 32'd1);
    for (int g = 0; g < 4; g++) begin
      @(negedge clock);
      chk($sformatf("mi gap%0d out", g), 32'(bus_b.io_out), 32'd0);
      chk($sformatf("mi gap%0d ready", g),
          32'(bus_b.io_in_ready), (g == 3) ? 32'd1 : 32'd0);
      chk($sformatf("mi gap%0d busy", g),
          32'(bus_b.io_busy), (g == 3) ? 32'd0 : 32'd1);
    end
    @(negedge clock);
    chk("mi start2", 32'(bus_b.io_out), 32'(SYM_START));
    bus_b.io_in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk($sformatf("mi f2 bit%0d", i),
          32'(bus_b.io_out), 32'(vt[3].syms[2*i +: 2]));
    end
    @(negedge clock);
    chk("mi f2 parity", 32'(bus_b.io_out), 32'(vt[3].par));
    @(negedge clock);
    chk("mi f2 gap", 32'(bus_b.io_out), 32'd0);

    // random frames decoded by an independent scoreboard
    for (int f = 0; f < 1000; f++) begin
      wait_ready_a();
      repeat ($urandom_range(0, 1)) @(negedge clock);
      w = 8'($urandom);
      bus_a.io_in_valid = 1'b1;
      bus_a.io_in_bits  = w;
      @(negedge clock);
      bus_a.io_in_valid = 1'b0;
      ok  = (bus_a.io_out === 2'b11) && (bus_a.io_busy === 1'b1);
      dec = '0;
      for (int i = 0; i < 8; i++) begin
        bus_a.io_in_bits = 8'($urandom);
        @(negedge clock);
        s = bus_a.io_out;
        if (s === 2'b10) dec[i] = 1'b1;
        else if (s !== 2'b01) ok = 1'b0;
        if (bus_a.io_busy !== 1'b1 || bus_a.io_done !== 1'b0) ok = 1'b0;
      end
      @(negedge clock);
      if (bus_a.io_out !== ((^w) ? 2'b10 : 2'b01)) ok = 1'b0;
      if (bus_a.io_done !== 1'b1 || bus_a.io_busy !== 1'b1) ok = 1'b0;
      @(negedge clock);
      if (bus_a.io_out !== 2'b00 || bus_a.io_busy !== 1'b0) ok = 1'b0;
      chk($sformatf("rand %0d data", f), 32'(dec), 32'(w));
      chk($sformatf("rand %0d frame", f), 32'(ok), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
